// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester side and UART_tx side of the shared transmitter.
// The arbiter takes the slave modport; requesters/UART model take master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      trmt;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      busy;
  logic [GID_W-1:0]          grant_id;
  logic                      tx_err;

  modport master (
    output req, req_data, tx_done,
    input  ack, trmt, tx_data, busy, grant_id, tx_err
  );

  modport slave (
    input  req, req_data, tx_done,
    output ack, trmt, tx_data, busy, grant_id, tx_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART_tx among NUM_REQ byte sources.
// Optional BUSY watchdog enabled by defining TX_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = GID_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [GID_W-1:0]     ptr;
  logic [GID_W-1:0]     ptr_nxt;
  logic [GID_W-1:0]     gid_q;
  logic [GID_W-1:0]     sel_idx;
  logic [DATA_W-1:0]    tx_data_q;
  logic [DATA_W-1:0]    sel_byte;
  logic [2*NUM_REQ-1:0] req2;
  logic [NUM_REQ-1:0]   rot;
  logic [SUM_W-1:0]     sel_sum;
  logic [SUM_W-1:0]     sel_wrap;
  logic                 sel_found;
  logic                 timeout;
  logic                 frame_end;

  // Rotate so bit 0 is the pointer; lowest set bit of rot is the winner.
  always_comb begin
    req2      = {bus.req, bus.req};
    rot       = NUM_REQ'(req2 >> ptr);
    sel_found = 1'b0;
    sel_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sel_found = 1'b1;
        sel_sum   = {1'b0, ptr} + SUM_W'(k);
      end
    end
    sel_wrap = (sel_sum >= SUM_W'(NUM_REQ)) ?
               sel_sum - SUM_W'(NUM_REQ) : sel_sum;
    sel_idx  = sel_wrap[GID_W-1:0];
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == GID_W'(i)) begin
        sel_byte = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_nxt   = (gid_q == GID_W'(NUM_REQ - 1)) ?
                     '0 : gid_q + 1'b1;
  assign frame_end = bus.tx_done || timeout;

  always_comb begin
    state_nxt = IDLE;
    bus.trmt  = 1'b0;
    bus.busy  = 1'b0;
    bus.ack   = '0;
    case (state)
      IDLE: begin
        state_nxt = sel_found ? START : IDLE;
      end
      START: begin
        state_nxt = BUSY;
        bus.trmt  = 1'b1;
        bus.busy  = 1'b1;
        bus.ack   = NUM_REQ'(1) << gid_q;
      end
      BUSY: begin
        state_nxt = frame_end ? IDLE : BUSY;
        bus.busy  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gid_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_found) begin
        tx_data_q <= sel_byte;
        gid_q     <= sel_idx;
      end
      if (state == BUSY && frame_end) begin
        ptr <= ptr_nxt;
      end
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.grant_id = gid_q;

`ifdef TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic             tx_err_q;

  // cnt is 0 in the first BUSY cycle; a tx_done on the limit cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tx_err_q <= 1'b0;
    end else begin
      cnt      <= (state == BUSY) ? cnt + 1'b1 : '0;
      tx_err_q <= timeout && !bus.tx_done;
    end
  end

  assign timeout    = (state == BUSY) &&
                      (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign bus.tx_err = tx_err_q;
`else
  assign timeout    = 1'b0;
  assign bus.tx_err = 1'b0;
`endif

endmodule
